// File: rtl/uart_baud_mgr.sv
`default_nettype none
// ============================================================================
// Module   : uart_baud_mgr
// Brief    : Chooses manual or auto-detected baud, runs detection attempts with
//            a watchdog and bounded retries, and re-arms on lost lock.
//            Optional macro UART_BAUD_MGR_SANITY_EN rejects det_baud_16x < 2.
// Revision : 1.0 - initial release
// ============================================================================
module uart_baud_mgr #(
  parameter int               TMO_W     = 24,
  parameter logic [TMO_W-1:0] TMO_VAL   = 24'hFF_FFFF,
  parameter int               ERR_THR   = 4,
  parameter int               RETRY_MAX = 7,
  parameter int               CLR_CYC   = 4
) (
  input  logic        mclk,
  input  logic        reset,
  input  logic        cfg_auto_en,
  input  logic [11:0] cfg_baud_16x,
  input  logic        cfg_tx_en,
  input  logic        cfg_rx_en,
  input  logic        cfg_restart,
  input  logic [11:0] det_baud_16x,
  input  logic        det_done,
  output logic        det_arm,
  output logic        det_clr,
  input  logic        rx_frm_err,
  input  logic        rx_byte_ok,
  output logic [11:0] baud_16x,
  output logic        tx_enb,
  output logic        rx_enb,
  output logic        sts_locked,
  output logic        sts_fail,
  output logic [3:0]  sts_retry_cnt
);

  localparam int             ERR_W     = $clog2(ERR_THR + 1);
  localparam int             CLR_W     = $clog2(CLR_CYC + 1);
  localparam logic [ERR_W-1:0] ERR_LAST  = ERR_W'(ERR_THR - 1);
  localparam logic [CLR_W-1:0] CLR_LAST  = CLR_W'(CLR_CYC - 1);
  localparam logic [3:0]       RETRY_LIM = 4'(RETRY_MAX);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_MANUAL    = 3'd1,
    ST_CLEAR     = 3'd2,
    ST_ARM       = 3'd3,
    ST_WAIT_LOCK = 3'd4,
    ST_LOCKED    = 3'd5,
    ST_FAIL      = 3'd6
  } state_t;

  state_t           r_state;
  logic [TMO_W-1:0] r_wdog;
  logic [ERR_W-1:0] r_err_cnt;
  logic [CLR_W-1:0] r_clr_cnt;

  logic             w_det_ok;
  logic             w_timeout;
  logic [3:0]       w_retry_next;

`ifdef UART_BAUD_MGR_SANITY_EN
  assign w_det_ok = det_done && (det_baud_16x >= 12'd2);
`else
  assign w_det_ok = det_done;
`endif

  assign w_timeout    = (r_wdog == TMO_VAL);
  assign w_retry_next = (sts_retry_cnt == 4'hF) ? 4'hF : sts_retry_cnt + 4'd1;

  always_ff @(posedge mclk) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      baud_16x      <= 12'd0;
      tx_enb        <= 1'b0;
      rx_enb        <= 1'b0;
      det_arm       <= 1'b0;
      det_clr       <= 1'b1;
      sts_locked    <= 1'b0;
      sts_fail      <= 1'b0;
      sts_retry_cnt <= 4'd0;
      r_wdog        <= '0;
      r_err_cnt     <= '0;
      r_clr_cnt     <= '0;
    end else if (!cfg_auto_en) begin
      r_state       <= ST_MANUAL;
      baud_16x      <= cfg_baud_16x;
      tx_enb        <= cfg_tx_en;
      rx_enb        <= cfg_rx_en;
      det_arm       <= 1'b0;
      det_clr       <= 1'b1;
      sts_locked    <= 1'b0;
      sts_fail      <= 1'b0;
      sts_retry_cnt <= 4'd0;
      r_err_cnt     <= '0;
    end else if (cfg_restart) begin
      r_state       <= ST_CLEAR;
      r_clr_cnt     <= '0;
      r_wdog        <= '0;
      r_err_cnt     <= '0;
      tx_enb        <= 1'b0;
      rx_enb        <= 1'b0;
      det_arm       <= 1'b0;
      det_clr       <= 1'b1;
      sts_locked    <= 1'b0;
      sts_fail      <= 1'b0;
      sts_retry_cnt <= 4'd0;
    end else begin
      case (r_state)
        ST_IDLE, ST_MANUAL: begin
          r_state   <= ST_CLEAR;
          r_clr_cnt <= '0;
          r_wdog    <= '0;
          tx_enb    <= 1'b0;
          rx_enb    <= 1'b0;
          det_arm   <= 1'b0;
          det_clr   <= 1'b1;
        end
        ST_CLEAR: begin
          tx_enb <= 1'b0;
          rx_enb <= 1'b0;
          r_wdog <= '0;
          if (r_clr_cnt == CLR_LAST) begin
            r_state <= ST_ARM;
            det_clr <= 1'b0;
            det_arm <= 1'b1;
          end else begin
            r_clr_cnt <= r_clr_cnt + CLR_W'(1);
          end
        end
        ST_ARM: begin
          r_state <= ST_WAIT_LOCK;
        end
        ST_WAIT_LOCK: begin
          if (w_det_ok) begin
            r_state       <= ST_LOCKED;
            baud_16x      <= det_baud_16x;
            tx_enb        <= 1'b1;
            rx_enb        <= 1'b1;
            sts_locked    <= 1'b1;
            sts_retry_cnt <= 4'd0;
            r_err_cnt     <= '0;
          end else if (det_done || w_timeout) begin
            // A rejected result costs a retry exactly like a watchdog expiry
            sts_retry_cnt <= w_retry_next;
            det_arm       <= 1'b0;
            det_clr       <= 1'b1;
            if (w_retry_next > RETRY_LIM) begin
              r_state  <= ST_FAIL;
              sts_fail <= 1'b1;
            end else begin
              r_state   <= ST_CLEAR;
              r_clr_cnt <= '0;
              r_wdog    <= '0;
            end
          end else begin
            r_wdog <= r_wdog + TMO_W'(1);
          end
        end
        ST_LOCKED: begin
          if (rx_byte_ok) begin
            r_err_cnt <= '0;
          end else if (rx_frm_err) begin
            if (r_err_cnt == ERR_LAST) begin
              r_state    <= ST_CLEAR;
              r_clr_cnt  <= '0;
              r_wdog     <= '0;
              r_err_cnt  <= '0;
              sts_locked <= 1'b0;
              tx_enb     <= 1'b0;
              rx_enb     <= 1'b0;
              det_arm    <= 1'b0;
              det_clr    <= 1'b1;
            end else begin
              r_err_cnt <= r_err_cnt + ERR_W'(1);
            end
          end
        end
        ST_FAIL: begin
          tx_enb <= 1'b0;
          rx_enb <= 1'b0;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
